// File: rtl/c432_bist_pkg.sv
// c432 BIST shared definitions: widths, FSM state, LFSR/MISR defaults.
// LFSR taps are 1-based positions in the 36-bit pattern register.
package c432_bist_pkg;

  localparam int PI_W  = 36;
  localparam int PO_W  = 7;
  localparam int SIG_W = 16;

  localparam logic [PI_W-1:0]  LFSR_SEED_DEF = 36'h1;
  localparam logic [SIG_W-1:0] MISR_POLY_DEF = 16'h1021;

  localparam int TAP_A = 36;
  localparam int TAP_B = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [PI_W-1:0] lfsr_step(
    input logic [PI_W-1:0] v
  );
    return {v[PI_W-2:0], v[TAP_A-1] ^ v[TAP_B-1]};
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(
    input logic [SIG_W-1:0] s,
    input logic [PO_W-1:0]  d,
    input logic [SIG_W-1:0] poly
  );
    logic [SIG_W-1:0] fb;
    fb = s[SIG_W-1] ? poly : '0;
    return {s[SIG_W-2:0], 1'b0} ^ fb
         ^ {{(SIG_W-PO_W){1'b0}}, d};
  endfunction

endpackage

// File: rtl/c432_bist_ctrl_if.sv
// Test-access side of the c432 BIST controller: run request and status.
// master = test-access logic, slave = BIST controller.
interface c432_bist_ctrl_if #(
  parameter int CNT_W = 36
) ();
  import c432_bist_pkg::*;

  logic             start;
  logic             mode;
  logic [CNT_W-1:0] pat_count;
  logic [SIG_W-1:0] golden_sig;
  logic             abort;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;

  modport master (
    output start, mode, pat_count,
    output golden_sig, abort,
    input  busy, done, pass, signature
  );

  modport slave (
    input  start, mode, pat_count,
    input  golden_sig, abort,
    output busy, done, pass, signature
  );

endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting CUT responses.
// clr has priority over en; din enters the low bits.
module bist_misr #(
  parameter int               SIG_W = 16,
  parameter int               PO_W  = 7,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [PO_W-1:0]  din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] fb;
  logic [SIG_W-1:0] nxt;

  assign fb  = sig[SIG_W-1] ? POLY : '0;
  assign nxt = {sig[SIG_W-2:0], 1'b0} ^ fb
             ^ {{(SIG_W-PO_W){1'b0}}, din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= nxt;
    end
  end

endmodule

// File: rtl/c432_bist_ctrl.sv
// BIST controller for c432: pattern generation, run FSM and
// golden-signature compare around a bist_misr compactor.
module c432_bist_ctrl
  import c432_bist_pkg::*;
#(
  parameter int               CNT_W     = 36,
  parameter logic [PI_W-1:0]  LFSR_SEED = LFSR_SEED_DEF,
  parameter logic [SIG_W-1:0] MISR_POLY = MISR_POLY_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  c432_bist_ctrl_if.slave bus,
  output logic [PI_W-1:0] cut_pi,
  input  logic [PO_W-1:0] cut_po
);

  state_t           state_q;
  state_t           state_d;
  logic [PI_W-1:0]  pi_q;
  logic [CNT_W-1:0] rem_q;
  logic             mode_q;
  logic [SIG_W-1:0] gold_q;
  logic             pass_q;
  logic [SIG_W-1:0] sig;
  logic             accept;
  logic             step;
  logic             last;
  logic             busy;
  logic             done;
  logic             zero_cnt;

  assign zero_cnt = (bus.pat_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (last) begin
          state_d = DONE;
        end
      end
      default: begin
        if (accept) begin
          state_d = zero_cnt ? DONE : RUN;
        end
      end
    endcase
  end

  // abort suppresses the whole RUN edge, so the MISR keeps its value
  always_comb begin
    accept = 1'b0;
    step   = 1'b0;
    last   = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (1'b1)
      (state_q == RUN): begin
        busy = 1'b1;
        step = !bus.abort;
        last = step && (rem_q == CNT_W'(1));
      end
      (state_q == DONE): begin
        done   = 1'b1;
        accept = bus.start;
      end
      default: begin
        accept = bus.start;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi_q   <= '0;
      rem_q  <= '0;
      mode_q <= 1'b0;
      gold_q <= '0;
      pass_q <= 1'b0;
    end else if (accept) begin
      pi_q   <= bus.mode ? '0 : LFSR_SEED;
      rem_q  <= bus.pat_count;
      mode_q <= bus.mode;
      gold_q <= bus.golden_sig;
      pass_q <= zero_cnt && (bus.golden_sig == '0);
    end else if (step) begin
      pi_q  <= mode_q ? pi_q + PI_W'(1) : lfsr_step(pi_q);
      rem_q <= rem_q - CNT_W'(1);
      if (last) begin
        pass_q <= (misr_step(sig, cut_po, MISR_POLY) == gold_q);
      end
    end
  end

  bist_misr #(
    .SIG_W (SIG_W),
    .PO_W  (PO_W),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (step),
    .din   (cut_po),
    .sig   (sig)
  );

  assign cut_pi        = pi_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass_q;
  assign bus.signature = sig;

endmodule

// File: tb/tb_c432_bist_ctrl.sv
// Scoreboard bench for c432_bist_ctrl: stimulus queues expected patterns
// and end-of-run results; a negedge monitor pops and compares them.
module tb_c432_bist_ctrl;
  import c432_bist_pkg::*;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic [15:0] sig;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [35:0] cut_pi;
  logic [6:0]  cut_po;
  int          po_sel = 0;
  logic [6:0]  po_tie = 7'h0;

  logic [35:0] exp_pi[$];
  res_t        exp_res[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  c432_bist_ctrl_if #(.CNT_W(36)) bus ();

  c432_bist_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .cut_pi (cut_pi),
    .cut_po (cut_po)
  );

  // behavioural stand-in for the CUT; bit 6 models N223
  function automatic logic [6:0] cut_fn(input logic [35:0] p);
    return {p[0] ^ p[2], p[1] & p[3], p[0] | p[3], ~p[2],
            p[3] ^ p[35], p[1], p[0] & p[2]};
  endfunction

  function automatic logic [15:0] ref_misr(
    input logic [15:0] s, input logic [6:0] d);
    logic [15:0] r;
    r = {s[14:0], 1'b0} ^ {9'b0, d};
    if (s[15]) r = r ^ 16'h1021;
    return r;
  endfunction

  assign cut_po = (po_sel == 0) ? po_tie :
                  (po_sel == 1) ? cut_fn(cut_pi) :
                  (cut_fn(cut_pi) & 7'h3F);

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_res(input logic d, input logic p,
                          input logic [15:0] s);
    res_t r;
    r.done = d;
    r.pass = p;
    r.sig  = s;
    exp_res.push_back(r);
  endtask

  logic pb = 1'b0;
  logic pd = 1'b0;
  res_t mr;

  always @(negedge clk) begin
    if (bus.busy) begin
      if (exp_pi.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cut_pi unexpected got %h", cut_pi);
      end else begin
        chk("cut_pi", 64'(cut_pi), 64'(exp_pi.pop_front()));
      end
    end
    if ((pb && !bus.busy) || (bus.done && !pd)) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result unexpected got done %b sig %h",
                 bus.done, bus.signature);
      end else begin
        mr = exp_res.pop_front();
        chk("done", 64'(bus.done), 64'(mr.done));
        chk("pass", 64'(bus.pass), 64'(mr.pass));
        chk("signature", 64'(bus.signature), 64'(mr.sig));
      end
    end
    pb = bus.busy;
    pd = bus.done;
  end

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_pi.size() != 0 || exp_res.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_pi.size() != 0 || exp_res.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout got %0d pending want 0",
               exp_pi.size() + exp_res.size());
      exp_pi.delete();
      exp_res.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic m, input logic [35:0] cnt,
                     input logic [15:0] gold);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.mode       = m;
    bus.pat_count  = cnt;
    bus.golden_sig = gold;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  logic [15:0] s_ok;
  logic [15:0] s_bad;

  initial begin
    bus.start      = 1'b0;
    bus.mode       = 1'b0;
    bus.pat_count  = '0;
    bus.golden_sig = '0;
    bus.abort      = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cut_pi", 64'(cut_pi), 64'h0);
    chk("rst_sig", 64'(bus.signature), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    chk("rst_pass", 64'(bus.pass), 64'h0);
    rst_n = 1'b1;

    // LFSR from seed 1, responses tied low
    po_sel = 0;
    po_tie = 7'h00;
    exp_pi.push_back(36'h1);
    exp_pi.push_back(36'h2);
    exp_pi.push_back(36'h4);
    exp_pi.push_back(36'h8);
    push_res(1'b1, 1'b1, 16'h0000);
    run(1'b0, 36'd4, 16'h0000);
    drain(20);

    // counter patterns, responses tied to 1
    po_tie = 7'h01;
    for (int i = 0; i < 3; i++) exp_pi.push_back(36'(i));
    push_res(1'b1, 1'b1, 16'h0007);
    run(1'b1, 36'd3, 16'h0007);
    drain(20);
    for (int i = 0; i < 3; i++) exp_pi.push_back(36'(i));
    push_res(1'b1, 1'b0, 16'h0007);
    run(1'b1, 36'd3, 16'h0006);
    drain(20);

    // CUT model, fault-free then N223 stuck-at-0
    po_sel = 1;
    s_ok = '0;
    s_bad = '0;
    for (int i = 0; i < 16; i++) begin
      exp_pi.push_back(36'(i));
      s_ok  = ref_misr(s_ok, cut_fn(36'(i)));
      s_bad = ref_misr(s_bad, cut_fn(36'(i)) & 7'h3F);
    end
    push_res(1'b1, 1'b1, s_ok);
    run(1'b1, 36'd16, s_ok);
    drain(40);
    po_sel = 2;
    for (int i = 0; i < 16; i++) exp_pi.push_back(36'(i));
    push_res(1'b1, 1'b0, s_bad);
    run(1'b1, 36'd16, s_ok);
    drain(40);

    // abort sampled at E2 of a 10-pattern run
    po_sel = 0;
    po_tie = 7'h00;
    exp_pi.push_back(36'h0);
    exp_pi.push_back(36'h1);
    push_res(1'b0, 1'b0, 16'h0000);
    run(1'b1, 36'd10, 16'h0000);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", 64'(bus.done), 64'h0);
      @(negedge clk);
    end
    drain(5);

    // zero-length run
    push_res(1'b1, 1'b1, 16'h0000);
    run(1'b1, 36'd0, 16'h0000);
    drain(5);

    // clean run with a start pulse while busy
    po_tie = 7'h01;
    for (int i = 0; i < 3; i++) exp_pi.push_back(36'(i));
    push_res(1'b1, 1'b1, 16'h0007);
    run(1'b1, 36'd3, 16'h0007);
    bus.start     = 1'b1;
    bus.mode      = 1'b0;
    bus.pat_count = 36'd5;
    @(negedge clk);
    bus.start = 1'b0;
    drain(20);

    // counter wrap from a forced preload
    po_tie = 7'h00;
    exp_pi.push_back(36'hF_FFFF_FFFE);
    exp_pi.push_back(36'hF_FFFF_FFFF);
    exp_pi.push_back(36'h0);
    push_res(1'b1, 1'b1, 16'h0000);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.mode       = 1'b1;
    bus.pat_count  = 36'd3;
    bus.golden_sig = 16'h0000;
    @(posedge clk);
    #1 force dut.pi_q = 36'hF_FFFF_FFFE;
    #1 release dut.pi_q;
    @(negedge clk);
    bus.start = 1'b0;
    drain(20);

    // asynchronous reset during E5 of a 20-pattern run
    po_tie = 7'h01;
    for (int i = 0; i < 5; i++) exp_pi.push_back(36'(i));
    push_res(1'b0, 1'b0, 16'h0000);
    run(1'b1, 36'd20, 16'h0000);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cut_pi", 64'(cut_pi), 64'h0);
    chk("arst_sig", 64'(bus.signature), 64'h0);
    chk("arst_busy", 64'(bus.busy), 64'h0);
    chk("arst_done", 64'(bus.done), 64'h0);
    chk("arst_pass", 64'(bus.pass), 64'h0);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.pat_count = 36'd3;
    repeat (2) @(negedge clk);
    chk("rst_start_busy", 64'(bus.busy), 64'h0);
    chk("rst_start_pi", 64'(cut_pi), 64'h0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    drain(5);
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 64'(bus.busy), 64'h0);
    chk("post_rst_done", 64'(bus.done), 64'h0);
    chk("queues_empty", 64'(exp_pi.size() + exp_res.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c432_bist_ctrl.md
# c432_bist_ctrl

Built-in self-test controller for the c432 combinational core (36 primary inputs, 7 primary outputs). It replaces the exhaustive off-chip pattern sweep with on-chip pattern generation (36-bit LFSR or binary counter) and output compaction (16-bit MISR). It then compares the final signature against a golden value. It sits between the test-access logic, which drives start/config, and the c432 instance, which it drives through cut_pi and observes through cut_po.

## Interface
- PI_W, 36, CUT input width
- PO_W, 7, CUT output width
- SIG_W, 16, MISR width
- CNT_W, 36, pattern-count width
- LFSR_SEED, 36'h1, first LFSR pattern; must be nonzero
- MISR_POLY, 16'h1021, MISR feedback polynomial (x^16+x^12+x^5+1)
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle request to run a test; sampled only in IDLE or DONE
- mode  in  1  0 = LFSR patterns, 1 = exhaustive counter patterns; sampled with start
- pat_count  in  CNT_W  number of patterns to apply; sampled with start
- golden_sig  in  SIG_W  expected signature; sampled with start
- abort  in  1  cancels a run in progress
- cut_pi  out  PI_W  pattern to CUT; bit 35 = N1 … bit 0 = N115
- cut_po  in  PO_W  CUT response; bit 6 = N223 … bit 0 = N432; combinational from cut_pi, valid the same cycle
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  signature == golden; valid while done
- signature  out  SIG_W  current MISR contents

## Operation
- FSM states and transitions:
  - IDLE, on start: go to RUN, or to DONE directly if pat_count == 0.
  - RUN, when the remaining count reaches 0: go to DONE.
  - RUN, on abort: go to IDLE.
  - DONE, on start: go to RUN (same rules as IDLE).
- On accepting start:
  - Load cut_pi with LFSR_SEED (mode 0) or 0 (mode 1).
  - Clear the MISR to 0.
  - Load the remaining count with pat_count.
  - Latch mode and golden_sig.
- Each RUN edge performs three updates together:
  - MISR absorbs cut_po: misr_next = (misr << 1) ^ (misr[15] ? MISR_POLY : 0) ^ {9'b0, cut_po}.
  - cut_pi advances to the next pattern.
  - The remaining count decrements by 1.
- LFSR update (Fibonacci): next = {lfsr[34:0], lfsr[35] ^ lfsr[24]}. It never reaches 0 from a nonzero seed.
- Counter update: +1 modulo 2^36. It wraps 36'hF_FFFF_FFFF to 0 silently.
- On the last RUN edge, pass is registered as (misr_next == latched golden_sig).
- When pat_count == 0, the controller enters DONE with signature 0 and pass = (golden_sig == 0).
- abort in IDLE or DONE is ignored. In RUN, abort is honoured even on the final edge, so DONE is not entered.
- start and abort in the same RUN cycle: abort wins and start is ignored.
- start in RUN is ignored.
- After abort, signature keeps its partial value, and done/pass are 0.

## Timing
- Reset values:
  - state IDLE
  - cut_pi 0
  - signature 0
  - busy 0
  - done 0
  - pass 0
  - remaining count 0
- start sampled at edge E0: busy=1 and the first pattern is on cut_pi after E0.
- Response k (k = 1..N) is absorbed at edge Ek.
- With N = pat_count: done=1, busy=0 and pass are valid after edge EN. Total is N+1 edges from start sampling.
- done and pass hold until the next accepted start. That start clears them at the same edge that enters RUN.
- Reset assertion mid-run forces all outputs to their reset values immediately, without waiting for a clock edge.

## Structure
- Shared package c432_bist_pkg holds:
  - PI_W, PO_W and SIG_W
  - the state enum (IDLE, RUN, DONE)
  - default LFSR_SEED and MISR_POLY
  - the LFSR tap positions (36, 25)
- One sub-module, bist_misr:
  - parameters SIG_W, PO_W, POLY
  - ports clk, rst_n, clr, en, din, sig
- The controller keeps the FSM, the pattern register and the counter.

## Test plan
- mode=0, seed 1, pat_count=4, cut_po tied 0: cut_pi sequence 1, 2, 4, 8; done after E4; signature 16'h0000; golden 0 -> pass=1.
- mode=1, pat_count=3, cut_po tied 7'h01: cut_pi 0, 1, 2; signature 16'h0007; golden 16'h0007 -> pass=1; golden 16'h0006 -> pass=0.
- mode=1, cut_po driven by the c432 model, pat_count=16: signature matches the bench reference model; then a stuck-at-0 is injected on N223 -> pass=0.
- abort asserted at E2 of a pat_count=10 run: state IDLE and busy=0 after E2, done never asserted; a following start runs cleanly.
- pat_count=0 with golden 0 -> done after E0 with pass=1. Counter wrap: with a bench-forced preload of 36'hF_FFFF_FFFE and pat_count=3, cut_pi steps FFFFFFFFE, FFFFFFFFF, 0.
- rst_n dropped mid-RUN (cycle 5 of 20): all outputs reset immediately; start ignored while rst_n=0.
